// File: rtl/serial_link_data_link_deserializer.sv
// serial_link_data_link_deserializer: rebuilds {payload, credits} frames from LSB-first phy beats
// Optional build macro: SERIAL_LINK_DESER_STATS_EN adds saturating frame/stall counters.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                drops any partial or held frame
//   beat_i/_valid_i/_ready_o        RX beat stream
//   payload_o/_valid_o/payload_ready_i  rebuilt payload stream
//   credits_o/credits_valid_o       credit field of the last frame, one-cycle pulse
//   beat_cnt_o, busy_o     next beat slot, collecting-or-holding status
//   stat_frames_o, stat_stall_cycles_o  (stats build only)
module serial_link_data_link_deserializer #(
    parameter int BeatWidth    = 32,
    parameter int PayloadWidth = 64,
    parameter int CreditWidth  = 8,
    localparam int FrameWidth  = PayloadWidth + CreditWidth,
    localparam int NumBeats    = (FrameWidth + BeatWidth - 1) / BeatWidth,
    localparam int CntWidth    = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [BeatWidth-1:0]    beat_i,
    input  logic                    beat_valid_i,
    output logic                    beat_ready_o,
    output logic [PayloadWidth-1:0] payload_o,
    output logic                    payload_valid_o,
    input  logic                    payload_ready_i,
    output logic [CreditWidth-1:0]  credits_o,
    output logic                    credits_valid_o,
    output logic [CntWidth-1:0]     beat_cnt_o,
`ifdef SERIAL_LINK_DESER_STATS_EN
    output logic [15:0]             stat_frames_o,
    output logic [15:0]             stat_stall_cycles_o,
`endif
    output logic                    busy_o
);
    localparam int PadWidth = NumBeats * BeatWidth - FrameWidth;

    typedef enum logic [1:0] {RxIdle, RxCollect, RxHold} state_e;

    state_e                   state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d, slot;
    logic [FrameWidth-1:0]    frame_q, frame_d;
    logic [NumBeats*BeatWidth-1:0] frame_w;
    logic [CreditWidth-1:0]   credits_q, credits_d;
    logic                     credits_valid_q, credits_valid_d;
    logic                     beat_acc, last_beat;

    always_comb begin
        slot         = (state_q == RxCollect) ? cnt_q : '0;
        // holding a frame: a new beat may only enter as the held one leaves
        beat_ready_o = ~flush_i & ((state_q == RxHold) ? payload_ready_i : 1'b1);
        beat_acc     = beat_valid_i & beat_ready_o;
        last_beat    = beat_acc & (slot == CntWidth'(NumBeats - 1));
        frame_w      = '0;
        frame_w[FrameWidth-1:0] = frame_q;
        if (beat_acc)
            frame_w[slot*BeatWidth +: BeatWidth] = beat_i;
        // padding above FrameWidth is dropped here
        frame_d         = frame_w[FrameWidth-1:0];
        cnt_d           = beat_acc ? (last_beat ? '0 : slot + CntWidth'(1)) : cnt_q;
        state_d         = state_q;
        if (beat_acc)
            state_d = last_beat ? RxHold : RxCollect;
        else if (state_q == RxHold && payload_ready_i)
            state_d = RxIdle;
        credits_valid_d = last_beat;
        credits_d       = last_beat ? frame_d[CreditWidth-1:0] : credits_q;
        if (flush_i) begin
            state_d         = RxIdle;
            cnt_d           = '0;
            frame_d         = '0;
            credits_valid_d = 1'b0;
            credits_d       = credits_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= RxIdle;
            cnt_q           <= '0;
            frame_q         <= '0;
            credits_q       <= '0;
            credits_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            frame_q         <= frame_d;
            credits_q       <= credits_d;
            credits_valid_q <= credits_valid_d;
        end
    end

    assign payload_o       = frame_q[FrameWidth-1:CreditWidth];
    assign payload_valid_o = (state_q == RxHold);
    assign credits_o       = credits_q;
    assign credits_valid_o = credits_valid_q;
    assign beat_cnt_o      = cnt_q;
    assign busy_o          = (state_q != RxIdle);

    generate
        if (PadWidth > 0) begin : g_pad
            logic pad_unused;
            assign pad_unused = ^frame_w[NumBeats*BeatWidth-1:FrameWidth];
        end
    endgenerate

`ifdef SERIAL_LINK_DESER_STATS_EN
    logic [15:0] stat_frames_q, stat_frames_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_frames_d = (payload_valid_o & payload_ready_i & ~flush_i & ~&stat_frames_q)
                        ? stat_frames_q + 16'd1 : stat_frames_q;
        stat_stall_d  = (payload_valid_o & ~payload_ready_i & ~&stat_stall_q)
                        ? stat_stall_q + 16'd1 : stat_stall_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_frames_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_frames_o       = stat_frames_q;
    assign stat_stall_cycles_o = stat_stall_q;
`endif

    a_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        payload_valid_o && !payload_ready_i |=> payload_valid_o && $stable(payload_o));

    generate
        if (NumBeats > 1) begin : g_credit_gap
            a_credit_gap: assert property (@(posedge clk_i) disable iff (rst_i)
                credits_valid_o |=> !credits_valid_o);
        end
    endgenerate
endmodule

// File: tb/tb_serial_link_data_link_deserializer.sv
// tb_serial_link_data_link_deserializer: scoreboard bench for the 3-beat default and a 1-beat (72-bit) build
module tb_serial_link_data_link_deserializer;
    logic        clk = 1'b0;
    logic        rst, flush, bvalid, bready, pvalid, pready, cvalid, busy;
    logic [31:0] beat;
    logic [63:0] pay;
    logic [7:0]  cred;
    logic [1:0]  cnt;
    logic [71:0] b1;
    logic        b1_valid, b1_ready, p1_valid, p1_ready, c1_valid, busy1;
    logic [63:0] p1;
    logic [7:0]  c1;
    logic [0:0]  cnt1;
    int          checks = 0, errors = 0, cyc = 0, stalls = 0, start;
    logic [63:0] q_pay[$], q1_pay[$];
    logic [7:0]  q_cred[$], q1_cred[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_link_data_link_deserializer u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .beat_i(beat), .beat_valid_i(bvalid),
        .beat_ready_o(bready), .payload_o(pay), .payload_valid_o(pvalid),
        .payload_ready_i(pready), .credits_o(cred), .credits_valid_o(cvalid),
        .beat_cnt_o(cnt), .busy_o(busy));

    serial_link_data_link_deserializer #(.BeatWidth(72)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .beat_i(b1), .beat_valid_i(b1_valid),
        .beat_ready_o(b1_ready), .payload_o(p1), .payload_valid_o(p1_valid),
        .payload_ready_i(p1_ready), .credits_o(c1), .credits_valid_o(c1_valid),
        .beat_cnt_o(cnt1), .busy_o(busy1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    always @(negedge clk) if (!rst) begin
        if (pvalid && pready && !flush) begin
            if (q_pay.size() == 0) unexpected("payload_extra", pay);
            else check("payload", pay, q_pay.pop_front());
        end
        if (cvalid) begin
            if (q_cred.size() == 0) unexpected("credit_extra", {56'h0, cred});
            else check("credits", {56'h0, cred}, {56'h0, q_cred.pop_front()});
        end
        if (p1_valid && p1_ready) begin
            if (q1_pay.size() == 0) unexpected("payload1_extra", p1);
            else check("payload1", p1, q1_pay.pop_front());
        end
        if (c1_valid) begin
            if (q1_cred.size() == 0) unexpected("credit1_extra", {56'h0, c1});
            else check("credits1", {56'h0, c1}, {56'h0, q1_cred.pop_front()});
        end
    end

    task automatic send_beat(input logic [31:0] b);
        int n = 0;
        beat   = b;
        bvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (bready) break;
            n++;
            if (n > 50) begin
                check("beat_accept_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bvalid = 1'b0;
        stalls += n;
    endtask

    task automatic send_frame(input logic [63:0] p, input logic [7:0] c, input bit push_pay);
        logic [95:0] f;
        f = {24'h0, p, c};
        if (push_pay) q_pay.push_back(p);
        q_cred.push_back(c);
        for (int i = 0; i < 3; i++) send_beat(f[i*32 +: 32]);
        check("pvalid_latency", {63'h0, pvalid}, 64'd1);
        check("cvalid_latency", {63'h0, cvalid}, 64'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] v1 [4];
        v1[0] = 72'h11_2233_4455_6677_8899;
        v1[1] = 72'hA0_B1C2_D3E4_F506_1728;
        v1[2] = 72'h00_0000_0000_0000_0001;
        v1[3] = 72'hFF_FFFF_FFFF_FFFF_FFFE;
        rst = 1; flush = 0; bvalid = 0; beat = 0; pready = 1;
        b1 = 0; b1_valid = 0; p1_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("rst_pvalid", {63'h0, pvalid}, 64'd0);
        check("rst_cvalid", {63'h0, cvalid}, 64'd0);
        check("rst_credits", {56'h0, cred}, 64'd0);
        check("rst_payload", pay, 64'd0);
        check("rst_cnt", {62'h0, cnt}, 64'd0);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_bready", {63'h0, bready}, 64'd1);
        step();

        q_pay.push_back(64'hDEADBEEF_01234567);
        q_cred.push_back(8'h05);
        send_beat(32'h23456705);
        check("cnt_b0", {62'h0, cnt}, 64'd1);
        check("busy_collect", {63'h0, busy}, 64'd1);
        send_beat(32'hADBEEF01);
        check("cnt_b1", {62'h0, cnt}, 64'd2);
        send_beat(32'h000000DE);
        check("t1_pvalid", {63'h0, pvalid}, 64'd1);
        check("t1_cvalid", {63'h0, cvalid}, 64'd1);
        check("t1_cnt", {62'h0, cnt}, 64'd0);
        step();
        check("t1_pulse_end", {63'h0, cvalid}, 64'd0);
        check("t1_idle", {63'h0, pvalid}, 64'd0);
        check("t1_cred_hold", {56'h0, cred}, 64'h05);

        stalls = 0;
        start  = cyc;
        send_frame(64'h11112222_33334444, 8'hA1, 1);
        check("b2b_first_cycle", 64'(cyc - start + 1), 64'd4);
        send_frame(64'h55556666_77778888, 8'hB2, 1);
        check("b2b_second_cycle", 64'(cyc - start + 1), 64'd7);
        check("b2b_stalls", 64'(stalls), 64'd0);
        step();

        pready = 0;
        send_frame(64'hCAFEF00D_12345678, 8'h3C, 1);
        beat   = 32'hFFFFFFFF;
        bvalid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_bready", {63'h0, bready}, 64'd0);
            check("stall_pvalid", {63'h0, pvalid}, 64'd1);
            check("stall_payload", pay, 64'hCAFEF00D_12345678);
        end
        step();
        pready = 1;
        stalls = 0;
        send_frame(64'h0BADC0DE_87654321, 8'h77, 1);
        check("stall_resume", 64'(stalls), 64'd0);
        step();

        send_beat(32'hAAAAAAAA);
        send_beat(32'hBBBBBBBB);
        flush  = 1;
        bvalid = 1;
        beat   = 32'hCCCCCCCC;
        @(negedge clk);
        check("flush_bready", {63'h0, bready}, 64'd0);
        step();
        flush  = 0;
        bvalid = 0;
        check("flush_cnt", {62'h0, cnt}, 64'd0);
        check("flush_busy", {63'h0, busy}, 64'd0);
        send_frame(64'h1, 8'h3, 1);
        step();

        pready = 0;
        send_frame(64'h01234567_89ABCDEF, 8'h5A, 0);
        step();
        check("hold_before_rst", {63'h0, pvalid}, 64'd1);
        rst = 1;
        step();
        rst = 0;
        check("rst_hold_pvalid", {63'h0, pvalid}, 64'd0);
        check("rst_hold_credits", {56'h0, cred}, 64'd0);
        check("rst_hold_cnt", {62'h0, cnt}, 64'd0);
        check("rst_hold_payload", pay, 64'd0);
        pready = 1;
        send_frame(64'h22223333_44445555, 8'h44, 1);
        step();

        for (int i = 0; i < 4; i++) begin
            q1_pay.push_back(v1[i][71:8]);
            q1_cred.push_back(v1[i][7:0]);
            b1       = v1[i];
            b1_valid = 1;
            @(negedge clk);
            check("nb1_bready", {63'h0, b1_ready}, 64'd1);
            if (i > 0) check("nb1_pvalid", {63'h0, p1_valid}, 64'd1);
            step();
        end
        b1_valid = 0;
        @(negedge clk);
        check("nb1_last_pvalid", {63'h0, p1_valid}, 64'd1);
        step();
        @(negedge clk);
        check("nb1_idle", {63'h0, p1_valid}, 64'd0);

        repeat (3) step();
        check("q_pay_empty", 64'(q_pay.size()), 64'd0);
        check("q_cred_empty", 64'(q_cred.size()), 64'd0);
        check("q1_pay_empty", 64'(q1_pay.size()), 64'd0);
        check("q1_cred_empty", 64'(q1_cred.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_link_data_link_deserializer.md
Name: serial_link_data_link_deserializer

Overview:
Receive-side counterpart of the data link send path. The send path shifts each {payload, credits} frame out LSB-first as BeatWidth-bit beats. This block collects those beats from the phy RX channel and rebuilds the frame. It presents the payload on a valid/ready interface and returns the embedded credit field as a one-cycle pulse to the credit synchronization logic, independent of payload backpressure.

Parameters:
BeatWidth, 32, bits per phy beat (NumChannels*NumLanes*2 of the link)
PayloadWidth, 64, payload field width
CreditWidth, 8, credit field width
FrameWidth (local), PayloadWidth+CreditWidth, frame size; frame = {payload, credits}, credits in LSBs
NumBeats (local), ceil(FrameWidth/BeatWidth), beats per frame; must be >= 1
CntWidth (local), max(1, $clog2(NumBeats)), beat index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  synchronous drop of partial and held frame
beat_i  in  BeatWidth  RX beat data
beat_valid_i  in  1  beat valid
beat_ready_o  out  1  beat accepted when valid&ready
payload_o  out  PayloadWidth  rebuilt payload
payload_valid_o  out  1  payload valid
payload_ready_i  in  1  payload consumer ready
credits_o  out  CreditWidth  credit field of the last completed frame
credits_valid_o  out  1  one-cycle credit pulse
beat_cnt_o  out  CntWidth  index of the next beat slot to fill
busy_o  out  1  high in RxCollect or RxHold

Behaviour:
- Storage: NumBeats x BeatWidth frame register. Beat k is written to frame bits [k*BeatWidth +: BeatWidth]. Bits at or above FrameWidth in the last beat are padding and are ignored.
- FSM states: RxIdle, RxCollect, RxHold. Reset and flush both force RxIdle with cnt=0.
- RxIdle:
  - beat_ready_o=1.
  - On an accepted beat: write slot 0.
  - If NumBeats==1: go to RxHold. Otherwise go to RxCollect with cnt=1.
- RxCollect:
  - beat_ready_o=1.
  - On an accepted beat: write slot cnt.
  - If cnt==NumBeats-1: cnt=0, go to RxHold. Otherwise cnt+1.
  - No beat: hold.
- RxHold:
  - payload_valid_o=1; payload_o and the credit field are sourced directly from the frame register.
  - beat_ready_o=payload_ready_i, so an incoming beat is back-pressured while the payload is stalled.
  - payload_ready_i=1 and no beat: go to RxIdle.
  - payload_ready_i=1 and a beat accepted in the same cycle: the beat is written to slot 0 and the next state is RxCollect (cnt=1), or RxHold again when NumBeats==1. There is no bubble: back-to-back frames sustain one beat per cycle.
  - payload_valid_o stays stable, and payload_o constant, until the handshake.
- Credits:
  - credits_valid_o is registered. It is 1 in the cycle after the final beat of a frame is accepted, which is the same cycle payload_valid_o first rises.
  - credits_o holds frame[CreditWidth-1:0] and stays stable until the next pulse.
  - Exactly one pulse per frame, regardless of payload stalls.
- Latency: last beat accepted at edge N; payload_valid_o and credits_valid_o are high from cycle N+1.
- Flush:
  - Highest priority below rst_i. Discards any partial or held frame.
  - No credit pulse is emitted, and a credits_valid_o pulse due in the same cycle is suppressed.
  - beat_ready_o=0 during the flush cycle.
- Reset values: payload_valid_o=0, credits_valid_o=0, credits_o=0, payload_o=0 (frame register cleared), beat_cnt_o=0, busy_o=0, beat_ready_o=1 once rst_i deasserts.
- Simultaneous events:
  - rst_i dominates flush_i, which dominates beat and payload handshakes.
  - A reset in the middle of a frame discards the frame; the next accepted beat is treated as beat 0.
- Assertions:
  - payload_o and payload_valid_o stable while valid & ~ready.
  - credits_valid_o never high on two consecutive cycles when NumBeats>1.

Optional Feature:
SERIAL_LINK_DESER_STATS_EN
- Defined: adds outputs stat_frames_o[15:0] and stat_stall_cycles_o[15:0], both zeroed by rst_i.
  - stat_frames_o increments on every payload handshake.
  - stat_stall_cycles_o increments every cycle in RxHold with payload_ready_i=0.
  - Both counters saturate at 16'hFFFF and are not cleared by flush_i.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Defaults (NumBeats=3), payload_ready_i=1: beats 32'h23456705, 32'hADBEEF01, 32'h000000DE -> one cycle after the 3rd beat, payload_o=64'hDEADBEEF_01234567 and credits_o=8'h05 with credits_valid_o=1 for 1 cycle.
- Back-to-back: two frames streamed 6 consecutive cycles, ready=1 -> beat_ready_o never drops; payloads appear at cycles 4 and 7.
- Stall: payload_ready_i=0 for 10 cycles after a frame -> payload_o stable, credits_valid_o pulses once, beat_ready_o=0 until ready; the next frame is intact.
- Flush after 2 beats, then a full frame with payload 64'h1, credits 8'h3 -> exactly one payload output (64'h1) and one credit pulse (8'h3).
- rst_i in the middle of RxHold with valid held -> next cycle payload_valid_o=0, credits_o=0, beat_cnt_o=0; a new frame is received correctly.
- BeatWidth=72 (NumBeats=1): single beats every cycle with ready=1 -> one payload and one credit pulse per cycle, with no bubbles.
